lsu_mem_port: RTL and testbench

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port.sv | 190 +++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: one outstanding access, lane steering and load extension.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses fault instead of being force-aligned.
module lsu_mem_port #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  store_q, store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            lsb_q, lsb_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DM_ADDRESS-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_fault_q, rsp_fault_d;
  logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic                  trap;
  logic [1:0]            lsb_eff;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  // Lane offset after dropping the address bits a wider access cannot use.
  function automatic logic [1:0] eff_lsb(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_lanes(input logic [2:0] f3, input logic [1:0] a,
                                                    input logic [DATA_W-1:0] wd);
    case (f3[1:0])
      2'b00:   return {{(DATA_W-8){1'b0}}, wd[7:0]} << {a, 3'b000};
      2'b01:   return {{(DATA_W-16){1'b0}}, wd[15:0]} << {a[1], 4'b0000};
      default: return wd;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                     input logic [DATA_W-1:0] word);
    logic [DATA_W-1:0] sh;
    sh = word >> {a, 3'b000};
    case (f3[1:0])
      2'b00:   return {{(DATA_W-8){sh[7] & ~f3[2]}}, sh[7:0]};
      2'b01:   return {{(DATA_W-16){sh[15] & ~f3[2]}}, sh[15:0]};
      default: return word;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(req_funct3, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign lsb_eff = eff_lsb(req_funct3, req_addr[1:0]);

  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    lsb_d       = lsb_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = rsp_fault_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        store_d  = req_store;
        funct3_d = req_funct3;
        lsb_d    = lsb_eff;
        if (trap) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          state_d     = S_REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = req_store;
          mem_addr_d  = {req_addr[DM_ADDRESS-1:2], 2'b00};
          mem_be_d    = req_store ? byte_en(req_funct3, lsb_eff) : 4'b1111;
          mem_wdata_d = req_store ? store_lanes(req_funct3, lsb_eff, req_wdata) : '0;
        end
      end
      S_REQ: if (mem_gnt) begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
        if (store_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (mem_rvalid) begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = load_extract(funct3_q, lsb_q, mem_rdata);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      store_q     <= 1'b0;
      funct3_q    <= '0;
      lsb_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      lsb_q       <= lsb_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a small word memory behind the port.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [8:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] model [0:127];

  logic [31:0] r_rdata, r_wdata;
  logic        r_fault, r_saw, r_we, r_stable, r_done;
  logic [8:0]  r_addr;
  logic [3:0]  r_be;
  int          r_lat;

  always #5 clk = ~clk;

  lsu_mem_port #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic mem_write();
    for (int i = 0; i < 4; i++)
      if (mem_be[i]) model[mem_addr[8:2]][8*i +: 8] = mem_wdata[8*i +: 8];
  endtask

  // One access: grant gd cycles after mem_req first rises, rvalid rd cycles after grant.
  task automatic access(input logic st, input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, input int gd, input int rd);
    int cyc, gcnt, since;
    logic granted;
    chk("acc_ready", req_ready, 1);
    req_valid = 1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    cyc = 1; gcnt = 0; since = 0; granted = 0;
    r_done = 0; r_saw = 0; r_stable = 1; r_lat = -1;
    r_rdata = 'x; r_fault = 'x; r_addr = 'x; r_be = 'x; r_wdata = 'x; r_we = 'x;
    while (!r_done && cyc < 60) begin
      mem_gnt = 0; mem_rvalid = 0;
      if (rsp_valid) begin
        r_done = 1; r_lat = cyc; r_rdata = rsp_rdata; r_fault = rsp_fault;
      end else begin
        if (mem_req) begin
          if (!r_saw) begin
            r_saw = 1; r_addr = mem_addr; r_be = mem_be; r_wdata = mem_wdata; r_we = mem_we;
          end else if ({mem_we, mem_be, mem_addr, mem_wdata} != {r_we, r_be, r_addr, r_wdata}) begin
            r_stable = 0;
          end
          if (gcnt == gd) begin
            mem_gnt = 1; granted = 1; since = 0;
            if (mem_we) mem_write();
          end else begin
            gcnt++;
          end
        end else if (granted && !st) begin
          since++;
          if (since == rd) begin
            mem_rvalid = 1; mem_rdata = model[r_addr[8:2]];
          end
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    mem_gnt = 0; mem_rvalid = 0;
    if (!r_done) begin
      chk("acc_timeout", 0, 1);
    end else begin
      @(posedge clk); #1;
      chk("rsp_one_cycle", rsp_valid, 0);
      chk("rsp_back_idle", req_ready, 1);
    end
  endtask

  initial begin
    int cyc, nacc, nrsp;
    int acc_c [2];
    int rsp_c [2];
    logic pend, acc, saw_rsp;
    logic [31:0] pdata, b2b_rdata;
    logic [8:0] ld_addr;

    for (int i = 0; i < 128; i++) model[i] = 32'h0;
    model[0] = 32'h0080_0000;
    model[1] = 32'h9ABC_1234;
    rst_n = 0; req_valid = 0; req_store = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    #22;
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_fault", rsp_fault, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // SB to 0x013, immediate grant
    access(1, 3'b000, 9'h013, 32'h0000_00AB, 0, 1);
    chk("sb_addr", r_addr, 9'h010);
    chk("sb_be", r_be, 4'b1000);
    chk("sb_wdata", r_wdata, 32'hAB00_0000);
    chk("sb_we", r_we, 1);
    chk("sb_lat", r_lat, 2);
    chk("sb_rdata", r_rdata, 0);
    chk("sb_fault", r_fault, 0);

    access(0, 3'b000, 9'h002, 32'h0, 0, 1);
    chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
    chk("lb_lat", r_lat, 3);
    chk("lb_be", r_be, 4'b1111);
    chk("lb_we", r_we, 0);
    chk("lb_addr", r_addr, 9'h000);

    access(0, 3'b100, 9'h002, 32'h0, 0, 1);
    chk("lbu_rdata", r_rdata, 32'h0000_0080);

    // LH with grant held off 3 cycles and rvalid 2 cycles after grant
    access(0, 3'b001, 9'h006, 32'h0, 3, 2);
    chk("lh_rdata", r_rdata, 32'hFFFF_9ABC);
    chk("lh_stable", r_stable, 1);
    chk("lh_lat", r_lat, 7);
    chk("lh_addr", r_addr, 9'h004);

    access(0, 3'b101, 9'h004, 32'h0, 0, 1);
    chk("lhu_rdata", r_rdata, 32'h0000_1234);

    access(0, 3'b000, 9'h013, 32'h0, 1, 3);
    chk("lb_readback", r_rdata, 32'hFFFF_FFAB);

    access(0, 3'b010, 9'h005, 32'h0, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_fault", r_fault, 1);
    chk("lw_mis_noreq", r_saw, 0);
    chk("lw_mis_rdata", r_rdata, 0);
    chk("lw_mis_lat", r_lat, 1);
`else
    chk("lw_mis_fault", r_fault, 0);
    chk("lw_mis_addr", r_addr, 9'h004);
    chk("lw_mis_rdata", r_rdata, 32'h9ABC_1234);
`endif

    access(1, 3'b001, 9'h006, 32'h0000_BEEF, 1, 1);
    chk("sh_be", r_be, 4'b1100);
    chk("sh_wdata", r_wdata, 32'hBEEF_0000);
    chk("sh_lat", r_lat, 3);

    // Reset while a load sits in WAIT, then a stray rvalid
    req_valid = 1; req_store = 0; req_funct3 = 3'b010; req_addr = 9'h008;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rw_mem_req", mem_req, 1);
    mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    #2 rst_n = 0;
    #1;
    chk("rw_ready", req_ready, 1);
    chk("rw_mem_req_off", mem_req, 0);
    chk("rw_rsp_valid", rsp_valid, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    saw_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      mem_rvalid = 0;
      if (rsp_valid) saw_rsp = 1;
    end
    chk("rw_no_rsp", saw_rsp, 0);
    chk("rw_ready_after", req_ready, 1);

    // SW then LW to 0x020 with req_valid held across both
    req_valid = 1; req_store = 1; req_funct3 = 3'b010; req_addr = 9'h020; req_wdata = 32'hCAFE_F00D;
    cyc = 0; nacc = 0; nrsp = 0; pend = 0; pdata = 0; b2b_rdata = 0; ld_addr = 0;
    acc_c[0] = -1; acc_c[1] = -1; rsp_c[0] = -1; rsp_c[1] = -1;
    while (cyc < 30 && nrsp < 2) begin
      mem_gnt = 0; mem_rvalid = 0;
      if (pend) begin mem_rvalid = 1; mem_rdata = pdata; pend = 0; end
      if (mem_req) begin
        mem_gnt = 1;
        if (mem_we) mem_write();
        else begin pend = 1; pdata = model[mem_addr[8:2]]; ld_addr = mem_addr; end
      end
      if (rsp_valid) begin
        rsp_c[nrsp] = cyc;
        nrsp++;
        if (nrsp == 1) chk("b2b_busy_at_rsp", req_ready, 0);
        else b2b_rdata = rsp_rdata;
      end
      acc = req_valid && req_ready;
      if (acc && nacc < 2) begin acc_c[nacc] = cyc; nacc++; end
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) req_store = 0;
      if (acc && nacc == 2) req_valid = 0;
    end
    req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
    chk("b2b_acc0", acc_c[0], 0);
    chk("b2b_acc1", acc_c[1], 3);
    chk("b2b_rsp0", rsp_c[0], 2);
    chk("b2b_rsp1", rsp_c[1], 6);
    chk("b2b_rdata", b2b_rdata, 32'hCAFE_F00D);
    chk("b2b_ld_addr", ld_addr, 9'h020);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
